// File: rtl/timer_pkg.sv
// Shared definitions for the multi-channel down-counter timer.
package timer_pkg;

  localparam int unsigned DEF_WIDTH = 10;
  localparam int unsigned DEF_NCH   = 4;

  // Mode captured per channel on load.
  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } mode_e;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: load/count/terminal with sticky done flag,
// one-cycle terminal pulse and one-shot/periodic reload.
module timer_chan
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  mode_e            mode_i,
  input  logic             enable_i,
  input  logic             clear_i,
  output logic             out_o,
  output logic             pulse_o,
  output logic             busy_o
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  mode_e            mode_q, mode_d;
  logic             busy_q, busy_d;
  logic             out_q, out_d;
  logic             pulse_q, pulse_d;

  // Next-state: load beats everything; terminal set beats clear.
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    busy_d   = busy_q;
    out_d    = out_q;
    pulse_d  = 1'b0;

    if (load_i) begin
      count_d  = data_i;
      reload_d = data_i;
      mode_d   = mode_i;
      out_d    = 1'b0;
      busy_d   = 1'b1;
    end else begin
      if (clear_i) begin
        out_d = 1'b0;
      end
      // A zero load completes on the next edge irrespective of mode or
      // enable, so a periodic channel loaded with 0 never free-runs.
      if (busy_q && (count_q == '0)) begin
        out_d   = 1'b1;
        pulse_d = 1'b1;
        busy_d  = 1'b0;
      end else if (busy_q && enable_i) begin
        if (count_q == WIDTH'(1)) begin
          out_d   = 1'b1;
          pulse_d = 1'b1;
          if (mode_q == MODE_PERIODIC) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            busy_d  = 1'b0;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  // Channel state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= MODE_ONESHOT;
      busy_q   <= 1'b0;
      out_q    <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      busy_q   <= busy_d;
      out_q    <= out_d;
      pulse_q  <= pulse_d;
    end
  end

  assign out_o   = out_q;
  assign pulse_o = pulse_q;
  assign busy_o  = busy_q;

endmodule

// File: rtl/timer_multi.sv
// N-channel down-counter timer: select decode, channel array, IRQ OR.
module timer_multi
  import timer_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned NCH   = DEF_NCH,
  localparam int unsigned SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             timer_clock,
  input  logic             timer_rstn,
  input  logic             timer_load,
  input  logic [SELW-1:0]  timer_sel,
  input  logic [WIDTH-1:0] timer_data,
  input  logic             timer_mode,
  input  logic [NCH-1:0]   timer_enable,
  input  logic [NCH-1:0]   timer_clear,
  output logic [NCH-1:0]   timer_out,
  output logic [NCH-1:0]   timer_pulse,
  output logic [NCH-1:0]   timer_busy,
  output logic             timer_irq
);

  logic [NCH-1:0] load_ch;

  // Route the load strobe to the addressed channel; out-of-range selects hit none.
  always_comb begin
    load_ch = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (timer_load && (timer_sel == SELW'(c))) begin
        load_ch[c] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    timer_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk_i    (timer_clock),
      .rst_ni   (timer_rstn),
      .load_i   (load_ch[g]),
      .data_i   (timer_data),
      .mode_i   (mode_e'(timer_mode)),
      .enable_i (timer_enable[g]),
      .clear_i  (timer_clear[g]),
      .out_o    (timer_out[g]),
      .pulse_o  (timer_pulse[g]),
      .busy_o   (timer_busy[g])
    );
  end

  assign timer_irq = |timer_out;

endmodule

// File: tb/tb_timer_multi.sv
// Self-checking bench for timer_multi: a behavioural channel model pushes
// expected outputs per edge into a scoreboard queue, popped after the edge.
module tb_timer_multi;

  localparam int unsigned WIDTH = 10;
  localparam int unsigned NCH   = 4;
  localparam int unsigned SELW  = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic             load;
  logic [SELW-1:0]  sel;
  logic [WIDTH-1:0] data;
  logic             mode;
  logic [NCH-1:0]   en;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   t_out, t_pulse, t_busy;
  logic             t_irq;

  timer_multi #(
    .WIDTH(WIDTH),
    .NCH  (NCH)
  ) dut (
    .timer_clock  (clk),
    .timer_rstn   (rstn),
    .timer_load   (load),
    .timer_sel    (sel),
    .timer_data   (data),
    .timer_mode   (mode),
    .timer_enable (en),
    .timer_clear  (clr),
    .timer_out    (t_out),
    .timer_pulse  (t_pulse),
    .timer_busy   (t_busy),
    .timer_irq    (t_irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0] out;
    logic [NCH-1:0] pulse;
    logic [NCH-1:0] busy;
    logic           irq;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  int   m_cnt [NCH];
  int   m_rel [NCH];
  bit   m_per [NCH];
  bit   m_busy[NCH];
  bit   m_out [NCH];
  bit   m_pul [NCH];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_cnt[c] = 0; m_rel[c] = 0; m_per[c] = 0;
      m_busy[c] = 0; m_out[c] = 0; m_pul[c] = 0;
    end
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      bit fire;
      if (load && (sel == SELW'(c))) begin
        m_cnt[c] = int'(data); m_rel[c] = int'(data); m_per[c] = mode;
        m_out[c] = 0; m_busy[c] = 1; m_pul[c] = 0;
      end else begin
        fire = m_busy[c] && ((m_cnt[c] == 0) || (en[c] && m_cnt[c] == 1));
        m_pul[c] = fire;
        if (fire) begin
          m_out[c] = 1;
          if (m_per[c] && m_cnt[c] == 1) m_cnt[c] = m_rel[c];
          else begin m_cnt[c] = 0; m_busy[c] = 0; end
        end else begin
          if (clr[c]) m_out[c] = 0;
          if (m_busy[c] && en[c]) m_cnt[c] = m_cnt[c] - 1;
        end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    if (!rstn) model_reset();
    else model_edge();
    for (int c = 0; c < NCH; c++) begin
      e.out[c] = m_out[c]; e.pulse[c] = m_pul[c]; e.busy[c] = m_busy[c];
    end
    e.irq = |e.out;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("out",   32'(t_out),   32'(e.out));
    check_eq("pulse", 32'(t_pulse), 32'(e.pulse));
    check_eq("busy",  32'(t_busy),  32'(e.busy));
    check_eq("irq",   32'(t_irq),   32'(e.irq));
  endtask

  task automatic do_load(input int ch, input int val, input bit md);
    load = 1'b1; sel = SELW'(ch); data = WIDTH'(val); mode = md;
    step();
    load = 1'b0;
  endtask

  initial begin : stim
    int n, t0, t3, np;
    rstn = 1'b0; load = 1'b0; sel = '0; data = '0; mode = 1'b0;
    en = '1; clr = '0;
    model_reset();

    // Reset state
    repeat (3) step();
    check_eq("rst_out", 32'(t_out), 32'h0);
    check_eq("rst_busy", 32'(t_busy), 32'h0);
    rstn = 1'b1;

    // Held load of ch0 N=5, expiry 5 edges after the last load edge
    load = 1'b1; sel = 0; data = 5; mode = 1'b0;
    repeat (4) step();
    load = 1'b0;
    n = 0;
    while (!t_out[0] && n < 20) begin step(); n++; end
    check_eq("t1_latency", 32'(n), 32'd5);
    check_eq("t1_pulse", 32'(t_pulse[0]), 32'd1);
    check_eq("t1_busy", 32'(t_busy[0]), 32'd0);
    repeat (3) step();
    check_eq("t1_sticky", 32'(t_out[0]), 32'd1);
    clr[0] = 1'b1; step(); clr[0] = 1'b0;
    check_eq("t1_cleared", 32'(t_out[0]), 32'd0);

    // Reset mid-count on ch1 aborts with no pulse
    do_load(1, 3, 1'b0);
    repeat (2) step();
    rstn = 1'b0;
    #1;
    model_reset();
    check_eq("midrst_busy", 32'(t_busy), 32'h0);
    check_eq("midrst_pulse", 32'(t_pulse), 32'h0);
    repeat (2) step();
    rstn = 1'b1;
    repeat (4) step();

    // Reload before expiry
    do_load(0, 4, 1'b0);
    repeat (2) step();
    do_load(0, 2, 1'b0);
    n = 0;
    while (!t_out[0] && n < 20) begin step(); n++; end
    check_eq("reload_latency", 32'(n), 32'd2);
    clr[0] = 1'b1; step(); clr[0] = 1'b0;

    // Periodic ch2 N=3: four pulses in twelve edges
    do_load(2, 3, 1'b1);
    np = 0;
    repeat (12) begin step(); np += int'(t_pulse[2]); end
    check_eq("per_pulses", 32'(np), 32'd4);
    check_eq("per_busy", 32'(t_busy[2]), 32'd1);
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    check_eq("per_clear", 32'(t_out[2]), 32'd0);
    n = 0;
    while (!t_pulse[2] && n < 10) begin step(); n++; end
    check_eq("per_reset_flag", 32'(t_out[2]), 32'd1);
    repeat (2) step();
    clr[2] = 1'b1; step(); clr[2] = 1'b0;
    check_eq("per_clr_vs_set_pulse", 32'(t_pulse[2]), 32'd1);
    check_eq("per_clr_vs_set_out", 32'(t_out[2]), 32'd1);
    do_load(2, 0, 1'b0);
    step();
    clr = '1; step(); clr = '0;

    // Pause ch0 for three edges; ch3 unaffected
    do_load(0, 6, 1'b0);
    do_load(3, 2, 1'b0);
    n = 1; t0 = -1; t3 = -1;
    en[0] = 1'b0;
    while ((t0 < 0 || t3 < 0) && n < 30) begin
      step(); n++;
      if (n == 4) en[0] = 1'b1;
      if (t_out[0] && t0 < 0) t0 = n;
      if (t_out[3] && t3 < 0) t3 = n;
    end
    check_eq("pause_ch3", 32'(t3), 32'd3);
    check_eq("pause_ch0", 32'(t0), 32'd9);
    clr = '1; step(); clr = '0;

    // Zero load, periodic: fires once next edge and stops
    do_load(1, 0, 1'b1);
    check_eq("zero_busy_loaded", 32'(t_busy[1]), 32'd1);
    step();
    check_eq("zero_out", 32'(t_out[1]), 32'd1);
    check_eq("zero_pulse", 32'(t_pulse[1]), 32'd1);
    check_eq("zero_busy", 32'(t_busy[1]), 32'd0);
    repeat (2) step();
    clr = '1; step(); clr = '0;

    // Maximum count
    do_load(3, 1023, 1'b0);
    n = 0;
    while (!t_out[3] && n < 1100) begin step(); n++; end
    check_eq("max_latency", 32'(n), 32'd1023);
    clr = '1; step(); clr = '0;

    // Periodic N=1: continuous pulse
    do_load(0, 1, 1'b1);
    repeat (5) begin
      step();
      check_eq("per1_pulse", 32'(t_pulse[0]), 32'd1);
    end

    check_eq("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_multi.md
Name: timer_multi

Overview:
- Parametrised multi-channel down-counter timer; next generation of the single-channel load/count/flag timer.
- Adds configurable count width, N independent channels, one-shot/periodic mode per channel, per-channel pause, and explicit flag clear.
- Sits on the peripheral side; the sticky flags and their OR-reduced interrupt feed the interrupt logic.

Parameters:
- WIDTH, 10, width of load value and counter per channel
- NCH, 4, number of independent channels (>=1)
- SELW, $clog2(NCH) (min 1), width of channel select; derived, not overridden

Ports:
- timer_clock  in  1  single clock; all state updates on rising edge
- timer_rstn  in  1  asynchronous active-low reset
- timer_load  in  1  load strobe for channel timer_sel
- timer_sel  in  SELW  channel addressed by timer_load
- timer_data  in  WIDTH  count value loaded
- timer_mode  in  1  mode captured on load: 0 one-shot, 1 periodic
- timer_enable  in  NCH  per-channel count enable (1 = count, 0 = pause)
- timer_clear  in  NCH  per-channel clear of sticky done flag
- timer_out  out  NCH  sticky done flag per channel
- timer_pulse  out  NCH  one-cycle terminal-count pulse per channel
- timer_busy  out  NCH  channel is actively timing
- timer_irq  out  1  OR of timer_out

Behaviour:
- Reset (async assert, sync release): all counters, reload values, modes, timer_out, timer_pulse, timer_busy = 0; timer_irq = 0. Reset mid-count aborts immediately; no pulse is emitted.
- Load (timer_load=1 at edge, channel c=timer_sel):
  - count[c] <= timer_data; reload[c] <= timer_data; mode[c] <= timer_mode.
  - timer_out[c] <= 0; busy[c] <= 1.
  - Load is honoured regardless of timer_enable.
- timer_sel >= NCH: load ignored; no state changes.
- Held load: each cycle reloads, so the count holds at N. Counting starts at the first edge after load deasserts.
- Load with timer_data=0: at the next edge, timer_out[c]=1 and timer_pulse[c]=1 for 1 cycle, busy[c]=0, regardless of mode (periodic with 0 is never free-running).
- Counting: if busy[c] and timer_enable[c] and no load, count[c] decrements by 1 per edge. A paused channel holds its count and emits no pulse.
- Latency: single-cycle load of N at edge k with enable high. The terminal edge is k+N; at that edge, timer_out and timer_pulse are registered high. timer_out is visible N cycles after the load edge.
- Terminal (count[c]==1 and decrementing):
  - One-shot: count <= 0, busy <= 0, out <= 1, pulse <= 1.
  - Periodic: count <= reload[c], busy stays 1, out <= 1, pulse <= 1. The period is exactly N cycles, with no dead cycle.
- timer_pulse deasserts the cycle after terminal unless the next terminal occurs (periodic N=1: pulse continuously high).
- timer_out is sticky. It stays high until timer_clear[c], a new load on c, or reset.
- Simultaneous events on one channel:
  - load + clear: load wins (out cleared, new count).
  - load + terminal: load wins; no pulse.
  - clear + terminal: set wins; out stays 1, pulse emitted.
  - enable low + load: load taken, count held afterwards.
- Channels are fully independent; events on one never affect another.
- Arithmetic: unsigned WIDTH bits; maximum count 2^WIDTH-1. No wrap below 0; the counter never decrements from 0.
- timer_irq is combinational OR of timer_out (the only combinational output).

Decomposition:
- Package timer_pkg: MODE_ONESHOT=1'b0, MODE_PERIODIC=1'b1; default WIDTH/NCH constants.
- Sub-module timer_chan: one channel with WIDTH count/reload, mode, busy, out, pulse. Its inputs are a per-channel load strobe (timer_load & sel decode), data, mode, enable, clear.
- timer_multi decodes timer_sel, generates NCH instances, and ORs the flags into timer_irq.

Test Plan:
- Reset: rstn low 3 cycles, then load ch0 N=5 one-shot, hold load 4 cycles -> out[0] rises 5 cycles after load release edge, pulse[0] 1 cycle, busy[0] falls, out[0] stays high until clear; irq follows.
- Reset mid-count: load ch1 N=3, assert rstn low after 2 cycles -> all outputs 0 immediately, no pulse after release.
- Reload before expiry: load ch0 N=4, after 2 cycles load ch0 N=2 -> out[0] rises exactly 2 cycles after second load, never at original expiry.
- Periodic: load ch2 N=3 mode=1 -> pulse[2] every 3 cycles for ≥4 periods, busy[2] stays 1; clear mid-stream -> out[2] drops and re-sets at next pulse; clear coincident with pulse -> out stays 1.
- Pause and independence: ch0 N=6, ch3 N=2 loaded back-to-back; drop enable[0] for 3 cycles -> ch0 expires 3 cycles late, ch3 on time; load with timer_sel=NCH (if NCH<2^SELW) -> no change.
- Edge values: load N=0 -> out/pulse next edge, busy 0; load N=2^WIDTH-1 one-shot -> expires after 1023 cycles (WIDTH=10); periodic N=1 -> pulse constantly high.
